rom_loader: RTL

ROM_LOADER -- requirements
Module: rom_loader

---
 rtl/rom_loader.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/rom_loader.sv
// Streams a length-prefixed, checksummed byte image into a word-wide ROM write port,
// holding the core while the load is in progress.
module rom_loader #(
  parameter int unsigned ROM_ADDR_WIDTH = 12,
  parameter int unsigned TIMEOUT        = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic        wr_en_o,
  output logic [31:0] wr_addr_o,
  output logic [31:0] wr_data_o,
  output logic        cpu_hold_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int unsigned MaxWords = 1 << (ROM_ADDR_WIDTH - 2);
  localparam logic [31:0] TmoLast  = 32'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StLen0, StLen1, StData, StCsum} state_e;

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [23:0] word_q, word_d;
  logic [7:0]  csum_q, csum_d;
  logic [31:0] tmo_q, tmo_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        wr_en_q, wr_en_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;

  logic        busy;
  logic        accept;
  logic [15:0] new_len;

  assign busy    = (state_q != StIdle);
  assign accept  = byte_valid_i && busy;
  assign new_len = {byte_data_i, len_q[7:0]};

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    word_idx_d = word_idx_q;
    word_d     = word_q;
    csum_d     = csum_q;
    tmo_d      = tmo_q;
    err_d      = err_q;
    done_d     = 1'b0;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d    = StLen0;
          len_d      = '0;
          byte_cnt_d = '0;
          word_idx_d = '0;
          word_d     = '0;
          csum_d     = '0;
          tmo_d      = '0;
          err_d      = 1'b0;
        end
      end
      StLen0: begin
        if (accept) begin
          len_d[7:0] = byte_data_i;
          state_d    = StLen1;
        end
      end
      StLen1: begin
        if (accept) begin
          len_d = new_len;
          if (new_len == 16'd0 || 32'(new_len) > MaxWords) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          csum_d     = csum_q + byte_data_i;
          byte_cnt_d = byte_cnt_q + 2'd1;
          word_d     = {byte_data_i, word_q[23:8]};
          if (byte_cnt_q == 2'd3) begin
            // Write is registered, so it lands the cycle after the 4th byte, even into CSUM.
            wr_en_d    = 1'b1;
            wr_addr_d  = {14'd0, word_idx_q, 2'b00};
            wr_data_d  = {byte_data_i, word_q};
            word_idx_d = word_idx_q + 16'd1;
            if (word_idx_q + 16'd1 == len_q) begin
              state_d = StCsum;
            end
          end
        end
      end
      StCsum: begin
        if (accept) begin
          if (byte_data_i == csum_q) begin
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // An accepted byte always beats a timeout expiring in the same cycle.
    if (busy) begin
      if (accept) begin
        tmo_d = '0;
      end else if (tmo_q == TmoLast) begin
        tmo_d   = '0;
        err_d   = 1'b1;
        state_d = StIdle;
      end else begin
        tmo_d = tmo_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      len_q      <= '0;
      byte_cnt_q <= '0;
      word_idx_q <= '0;
      word_q     <= '0;
      csum_q     <= '0;
      tmo_q      <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      word_idx_q <= word_idx_d;
      word_q     <= word_d;
      csum_q     <= csum_d;
      tmo_q      <= tmo_d;
      err_q      <= err_d;
      done_q     <= done_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign byte_ready_o = busy;
  assign busy_o       = busy;
  assign cpu_hold_o   = busy;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;

endmodule
